// File: rtl/regf_arb_pkg.sv
// Shared types for the regf memory-port arbiter: owner ID, command record and default widths.
package regf_arb_pkg;

    localparam int unsigned RegfAw = 13;
    localparam int unsigned RegfDw = 32;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } regf_owner_e;

    typedef struct packed {
        logic [RegfAw-1:0] addr;
        logic              wena;
        logic [RegfDw-1:0] wdata;
        regf_owner_e       owner;
    } regf_cmd_t;

endpackage

// File: rtl/regf_mem_arb_if.sv
// Bundle of both requester ports and the shared regf port; directions named from the arbiter's view.
interface regf_mem_arb_if
    import regf_arb_pkg::*;
#(
    parameter int unsigned AW = RegfAw,
    parameter int unsigned DW = RegfDw
);

    logic          a_req_i;
    logic [AW-1:0] a_addr_i;
    logic          a_wena_i;
    logic [DW-1:0] a_wdata_i;
    logic          a_gnt_o;
    logic          a_rvalid_o;
    logic [DW-1:0] a_rdata_o;
    logic          a_err_o;

    logic          b_req_i;
    logic [AW-1:0] b_addr_i;
    logic          b_wena_i;
    logic [DW-1:0] b_wdata_i;
    logic          b_gnt_o;
    logic          b_rvalid_o;
    logic [DW-1:0] b_rdata_o;
    logic          b_err_o;

    logic          mem_ena_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_wena_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;

    // Arbiter side.
    modport slave (
        input  a_req_i, a_addr_i, a_wena_i, a_wdata_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o,
        input  b_req_i, b_addr_i, b_wena_i, b_wdata_i,
        output b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o,
        output mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
        input  mem_rdata_i, mem_err_i
    );

    // Requesters plus regf side.
    modport master (
        output a_req_i, a_addr_i, a_wena_i, a_wdata_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o, a_err_o,
        output b_req_i, b_addr_i, b_wena_i, b_wdata_i,
        input  b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o,
        input  mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
        output mem_rdata_i, mem_err_i
    );

endinterface

// File: rtl/regf_rr_arb2.sv
// Two-way round-robin grant with a last-winner flop; A wins the first tie after reset.
module regf_rr_arb2
    import regf_arb_pkg::*;
(
    input  logic main_clk_i,
    input  logic main_rst_an_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    regf_owner_e lw_q, lw_d;

    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        lw_d    = lw_q;
        if (a_req_i && b_req_i) begin
            // On a tie the port that did not win last time goes next.
            if (lw_q == OWN_B) begin
                a_gnt_o = 1'b1;
            end else begin
                b_gnt_o = 1'b1;
            end
        end else if (a_req_i) begin
            a_gnt_o = 1'b1;
        end else if (b_req_i) begin
            b_gnt_o = 1'b1;
        end
        if (a_gnt_o) begin
            lw_d = OWN_A;
        end else if (b_gnt_o) begin
            lw_d = OWN_B;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            lw_q <= OWN_B;
        end else begin
            lw_q <= lw_d;
        end
    end

endmodule

// File: rtl/regf_mem_arb.sv
// Shares one regf memory port between two requesters: grant, command stage, response stage, steering.
module regf_mem_arb
    import regf_arb_pkg::*;
#(
    parameter int unsigned AW = RegfAw,
    parameter int unsigned DW = RegfDw
) (
    input logic           main_clk_i,
    input logic           main_rst_an_i,
    regf_mem_arb_if.slave bus
);

    logic a_gnt, b_gnt;

    logic          cmd_vld_q, cmd_vld_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic          cmd_wena_q, cmd_wena_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    regf_owner_e   cmd_owner_q, cmd_owner_d;

    logic          rsp_vld_q, rsp_vld_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    regf_owner_e   rsp_owner_q, rsp_owner_d;

    logic a_sel, b_sel;

    regf_rr_arb2 u_arb (
        .main_clk_i    (main_clk_i),
        .main_rst_an_i (main_rst_an_i),
        .a_req_i       (bus.a_req_i),
        .b_req_i       (bus.b_req_i),
        .a_gnt_o       (a_gnt),
        .b_gnt_o       (b_gnt)
    );

    always_comb begin
        cmd_vld_d   = a_gnt | b_gnt;
        cmd_addr_d  = bus.a_addr_i;
        cmd_wena_d  = bus.a_wena_i;
        cmd_wdata_d = bus.a_wdata_i;
        cmd_owner_d = OWN_A;
        if (b_gnt) begin
            cmd_addr_d  = bus.b_addr_i;
            cmd_wena_d  = bus.b_wena_i;
            cmd_wdata_d = bus.b_wdata_i;
            cmd_owner_d = OWN_B;
        end
    end

    // The regf decodes combinationally, so its response is captured in the access cycle.
    always_comb begin
        rsp_vld_d   = cmd_vld_q;
        rsp_owner_d = cmd_owner_q;
        rsp_rdata_d = (cmd_vld_q && !cmd_wena_q) ? bus.mem_rdata_i : '0;
        rsp_err_d   = cmd_vld_q & bus.mem_err_i;
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            cmd_vld_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wena_q  <= 1'b0;
            cmd_wdata_q <= '0;
            cmd_owner_q <= OWN_A;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_owner_q <= OWN_A;
        end else begin
            cmd_vld_q   <= cmd_vld_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wena_q  <= cmd_wena_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_owner_q <= cmd_owner_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    always_comb begin
        a_sel = rsp_vld_q && (rsp_owner_q == OWN_A);
        b_sel = rsp_vld_q && (rsp_owner_q == OWN_B);

        bus.a_gnt_o    = a_gnt;
        bus.b_gnt_o    = b_gnt;

        bus.mem_ena_o   = cmd_vld_q;
        bus.mem_addr_o  = cmd_vld_q ? cmd_addr_q : '0;
        bus.mem_wena_o  = cmd_vld_q & cmd_wena_q;
        bus.mem_wdata_o = cmd_vld_q ? cmd_wdata_q : '0;

        bus.a_rvalid_o = a_sel;
        bus.a_rdata_o  = a_sel ? rsp_rdata_q : '0;
        bus.a_err_o    = a_sel & rsp_err_q;
        bus.b_rvalid_o = b_sel;
        bus.b_rdata_o  = b_sel ? rsp_rdata_q : '0;
        bus.b_err_o    = b_sel & rsp_err_q;
    end

endmodule

// File: tb/tb_regf_mem_arb.sv
// Directed bench for regf_mem_arb: per-cycle vector table plus a hand-written reset-in-flight sequence.
module tb_regf_mem_arb;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;

    regf_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    regf_mem_arb #(.AW(AW), .DW(DW)) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small regf model: words 0..3 decoded, everything else flags an error.
    logic [DW-1:0] mem [4] = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};

    always_comb begin
        bus.mem_rdata_i = '0;
        bus.mem_err_i   = 1'b0;
        if (bus.mem_ena_o) begin
            if (bus.mem_addr_o < 13'd4) begin
                bus.mem_rdata_i = mem[bus.mem_addr_o[1:0]];
            end else begin
                bus.mem_err_i = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_ena_o && bus.mem_wena_o && (bus.mem_addr_o < 13'd4)) begin
            mem[bus.mem_addr_o[1:0]] <= bus.mem_wdata_o;
        end
    end

    typedef struct {
        logic          rst;
        logic [1:0]    req;     // {a, b}
        logic [AW-1:0] a_addr;
        logic          a_wena;
        logic [DW-1:0] a_wdata;
        logic [AW-1:0] b_addr;
        logic          b_wena;
        logic [DW-1:0] b_wdata;
        logic [1:0]    gnt;     // {a, b}
        logic          me;
        logic [AW-1:0] ma;
        logic          mw;
        logic [DW-1:0] md;
        logic [1:0]    rv;      // {a, b}
        logic [DW-1:0] ard;
        logic [DW-1:0] brd;
        logic [1:0]    err;     // {a, b}
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic [1:0] req,
        input logic [AW-1:0] aa, input logic aw, input logic [DW-1:0] ad,
        input logic [AW-1:0] ba, input logic bw, input logic [DW-1:0] bd,
        input logic [1:0] gnt, input logic me, input logic [AW-1:0] ma,
        input logic mw, input logic [DW-1:0] md,
        input logic [1:0] rv, input logic [DW-1:0] ard, input logic [DW-1:0] brd,
        input logic [1:0] err);
        vec_t r;
        r.rst = rst;   r.req = req;
        r.a_addr = aa; r.a_wena = aw; r.a_wdata = ad;
        r.b_addr = ba; r.b_wena = bw; r.b_wdata = bd;
        r.gnt = gnt;   r.me = me; r.ma = ma; r.mw = mw; r.md = md;
        r.rv = rv;     r.ard = ard; r.brd = brd; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        rst_n         = ~r.rst;
        bus.a_req_i   = r.req[1];
        bus.a_addr_i  = r.a_addr;
        bus.a_wena_i  = r.a_wena;
        bus.a_wdata_i = r.a_wdata;
        bus.b_req_i   = r.req[0];
        bus.b_addr_i  = r.b_addr;
        bus.b_wena_i  = r.b_wena;
        bus.b_wdata_i = r.b_wdata;
    endtask

    task automatic compare(input int i, input vec_t r);
        string p;
        p = $sformatf("row%0d", i);
        check({p, " a_gnt"},     32'(bus.a_gnt_o),     32'(r.gnt[1]));
        check({p, " b_gnt"},     32'(bus.b_gnt_o),     32'(r.gnt[0]));
        check({p, " mem_ena"},   32'(bus.mem_ena_o),   32'(r.me));
        check({p, " mem_addr"},  32'(bus.mem_addr_o),  32'(r.ma));
        check({p, " mem_wena"},  32'(bus.mem_wena_o),  32'(r.mw));
        check({p, " mem_wdata"}, bus.mem_wdata_o,      r.md);
        check({p, " a_rvalid"},  32'(bus.a_rvalid_o),  32'(r.rv[1]));
        check({p, " a_rdata"},   bus.a_rdata_o,        r.ard);
        check({p, " a_err"},     32'(bus.a_err_o),     32'(r.err[1]));
        check({p, " b_rvalid"},  32'(bus.b_rvalid_o),  32'(r.rv[0]));
        check({p, " b_rdata"},   bus.b_rdata_o,        r.brd);
        check({p, " b_err"},     32'(bus.b_err_o),     32'(r.err[0]));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.a_req_i   = 1'b0;
        bus.a_addr_i  = '0;
        bus.a_wena_i  = 1'b0;
        bus.a_wdata_i = '0;
        bus.b_req_i   = 1'b0;
        bus.b_addr_i  = '0;
        bus.b_wena_i  = 1'b0;
        bus.b_wdata_i = '0;

        // Reset state, then single A read of addr 0.
        vecs.push_back(v(1'b1, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b10, '0, '0, '0, '0, '0, '0, 2'b10, '0, '0, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 1'b1, '0, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0,
                         2'b10, 32'h10, '0, 2'b00));
        // B read of undecoded addr 4.
        vecs.push_back(v(1'b0, 2'b01, '0, '0, '0, 13'h4, '0, '0, 2'b01, '0, '0, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 1'b1, 13'h4, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0, 2'b01, '0, '0, 2'b01));
        // Reset, then tie: A read addr 1 vs B write 1 to addr 0.
        vecs.push_back(v(1'b1, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b11, 13'h1, '0, '0, '0, 1'b1, 32'h1, 2'b10, '0, '0, '0, '0,
                         2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b01, '0, '0, '0, '0, 1'b1, 32'h1, 2'b01, 1'b1, 13'h1, '0, '0,
                         2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 1'b1, '0, 1'b1, 32'h1,
                         2'b10, 32'h11, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0, 2'b01, '0, '0, 2'b00));
        // Both requesting for 8 cycles: A reads addr 2, B reads addr 3.
        for (int k = 0; k < 8; k++) begin
            logic [1:0]    g;
            logic          me;
            logic [AW-1:0] ma;
            logic [1:0]    rv;
            g  = k[0] ? 2'b01 : 2'b10;
            me = (k >= 1);
            ma = (k == 0) ? 13'h0 : (k[0] ? 13'h2 : 13'h3);
            rv = (k < 2) ? 2'b00 : (k[0] ? 2'b01 : 2'b10);
            vecs.push_back(v(1'b0, 2'b11, 13'h2, '0, '0, 13'h3, '0, '0, g, me, ma, '0, '0, rv,
                             rv[1] ? 32'h22 : 32'h0, rv[0] ? 32'h33 : 32'h0, 2'b00));
        end
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 1'b1, 13'h3, '0, '0,
                         2'b10, 32'h22, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0,
                         2'b01, '0, 32'h33, 2'b00));
        // B write CAFE, A write 1, A read back: all to addr 0, back to back.
        vecs.push_back(v(1'b0, 2'b01, '0, '0, '0, '0, 1'b1, 32'hCAFE, 2'b01, '0, '0, '0, '0,
                         2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b10, '0, 1'b1, 32'h1, '0, '0, '0, 2'b10, 1'b1, '0, 1'b1, 32'hCAFE,
                         2'b00, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b10, '0, '0, '0, '0, '0, '0, 2'b10, 1'b1, '0, 1'b1, 32'h1,
                         2'b01, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 1'b1, '0, '0, '0,
                         2'b10, '0, '0, 2'b00));
        vecs.push_back(v(1'b0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0,
                         2'b10, 32'h1, '0, 2'b00));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            compare(i, vecs[i]);
        end

        // Reset in the cycle after a grant; last winner is A before the reset.
        @(posedge clk); #1;
        bus.a_req_i  = 1'b1;
        bus.a_addr_i = 13'h1;
        bus.a_wena_i = 1'b0;
        @(negedge clk);
        check("rst_seq grant a_gnt", 32'(bus.a_gnt_o), 32'd1);
        @(posedge clk); #1;
        bus.a_req_i = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        check("rst_seq in reset mem_ena", 32'(bus.mem_ena_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq a_rvalid", 32'(bus.a_rvalid_o), 32'd0);
        check("rst_seq b_rvalid", 32'(bus.b_rvalid_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("rst_seq post%0d mem_ena", k), 32'(bus.mem_ena_o), 32'd0);
            check($sformatf("rst_seq post%0d a_rvalid", k), 32'(bus.a_rvalid_o), 32'd0);
            check($sformatf("rst_seq post%0d b_rvalid", k), 32'(bus.b_rvalid_o), 32'd0);
            @(posedge clk); #1;
        end
        bus.a_req_i  = 1'b1;
        bus.a_addr_i = 13'h2;
        bus.b_req_i  = 1'b1;
        bus.b_addr_i = 13'h3;
        bus.b_wena_i = 1'b0;
        @(negedge clk);
        check("rst_seq tie a_gnt", 32'(bus.a_gnt_o), 32'd1);
        check("rst_seq tie b_gnt", 32'(bus.b_gnt_o), 32'd0);
        @(posedge clk); #1;
        bus.a_req_i = 1'b0;
        bus.b_req_i = 1'b0;
        @(negedge clk);
        check("rst_seq tie mem_addr", 32'(bus.mem_addr_o), 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq tie a_rdata", bus.a_rdata_o, 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
